// File: rtl/ili9341_init_seq.sv
// ILI9341 power-up sequencer: hardware reset request, then a ROM-driven command/data/delay table.
// Optional macro INIT_SEQ_SWRESET_EN prefixes the table with a software reset (0x01) and a long delay.
module ili9341_init_seq #(
   parameter int unsigned WAIT_120MS = 480_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   output logic       o_reset_ena,
   output logic       o_reset_val,
   input  logic       i_reset_sent,
   output logic       o_spi_valid,
   output logic       o_spi_dc,
   output logic [7:0] o_spi_data,
   input  logic       i_spi_ready,
   output logic       o_busy,
   output logic       o_init_done
);

   localparam int unsigned CNT_W = (WAIT_120MS > 1) ? $clog2(WAIT_120MS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_120MS - 1);

   localparam logic [1:0] T_CMD   = 2'b00;
   localparam logic [1:0] T_DATA  = 2'b01;
   localparam logic [1:0] T_DELAY = 2'b10;
   localparam logic [1:0] T_END   = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      HW_RST,
      RST_WAIT,
      FETCH,
      SEND,
      DELAY,
      DONE
   } state_t;

   state_t           state;
   logic [3:0]       ptr;
   logic [3:0]       ptr_inc;
   logic [CNT_W-1:0] cnt;
   logic [9:0]       entry;

   // Entries past the end of the table read back as END so a stray pointer can only stop.
   function automatic logic [9:0] rom_entry(input logic [3:0] idx);
      logic [9:0] e;
      e = {T_END, 8'h00};
`ifdef INIT_SEQ_SWRESET_EN
      case (idx)
         4'd0:    e = {T_CMD,   8'h01};
         4'd1:    e = {T_DELAY, 8'h00};
         4'd2:    e = {T_CMD,   8'h11};
         4'd3:    e = {T_DELAY, 8'h00};
         4'd4:    e = {T_CMD,   8'h3A};
         4'd5:    e = {T_DATA,  8'h55};
         4'd6:    e = {T_CMD,   8'h36};
         4'd7:    e = {T_DATA,  8'h48};
         4'd8:    e = {T_CMD,   8'h29};
         4'd9:    e = {T_DELAY, 8'h00};
         default: e = {T_END,   8'h00};
      endcase
`else
      case (idx)
         4'd0:    e = {T_CMD,   8'h11};
         4'd1:    e = {T_DELAY, 8'h00};
         4'd2:    e = {T_CMD,   8'h3A};
         4'd3:    e = {T_DATA,  8'h55};
         4'd4:    e = {T_CMD,   8'h36};
         4'd5:    e = {T_DATA,  8'h48};
         4'd6:    e = {T_CMD,   8'h29};
         4'd7:    e = {T_DELAY, 8'h00};
         default: e = {T_END,   8'h00};
      endcase
`endif
      return e;
   endfunction

   always_comb begin
      entry   = rom_entry(ptr);
      ptr_inc = (ptr == '1) ? ptr : ptr + 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         o_reset_ena <= 1'b0;
         o_reset_val <= 1'b1;
         o_spi_valid <= 1'b0;
         o_spi_dc    <= 1'b0;
         o_spi_data  <= '0;
         o_busy      <= 1'b0;
         o_init_done <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state       <= HW_RST;
                  o_reset_ena <= 1'b1;
                  o_reset_val <= 1'b0;
                  o_busy      <= 1'b1;
                  o_init_done <= 1'b0;
               end
            end
            HW_RST: begin
               state       <= RST_WAIT;
               o_reset_ena <= 1'b0;
               o_reset_val <= 1'b1;
            end
            RST_WAIT: begin
               if (i_reset_sent) begin
                  ptr   <= '0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               case (entry[9:8])
                  T_CMD, T_DATA: begin
                     state       <= SEND;
                     o_spi_valid <= 1'b1;
                     o_spi_dc    <= entry[8];
                     o_spi_data  <= entry[7:0];
                  end
                  T_DELAY: begin
                     state <= DELAY;
                     cnt   <= CNT_LOAD;
                  end
                  default: begin
                     state       <= DONE;
                     o_busy      <= 1'b0;
                     o_init_done <= 1'b1;
                  end
               endcase
            end
            SEND: begin
               // Returning through FETCH guarantees a valid-low cycle between bytes.
               if (i_spi_ready) begin
                  ptr         <= ptr_inc;
                  state       <= FETCH;
                  o_spi_valid <= 1'b0;
                  o_spi_dc    <= 1'b0;
                  o_spi_data  <= '0;
               end
            end
            DELAY: begin
               if (cnt == '0) begin
                  ptr   <= ptr_inc;
                  state <= FETCH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ili9341_init_seq.md
ILI9341_INIT_SEQ -- requirements
Module: ili9341_init_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk and rst.
REQ-002 Parameter WAIT_120MS, default 480_000, cycles per long delay (120 ms at 4 MHz).
REQ-003 Port clk  in  1  system clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  asynchronous active-low reset.
REQ-005 Port i_start  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
REQ-006 Port o_reset_ena  out  1  one-cycle request to the hardware-reset stage.
REQ-007 Port o_reset_val  out  1  reset level for that stage; LOW whenever o_reset_ena is high.
REQ-008 Port i_reset_sent  in  1  completion pulse from the reset stage.
REQ-009 Port o_spi_valid  out  1  byte offer to the SPI sender.
REQ-010 Port o_spi_dc  out  1  0 = command, 1 = data; valid while o_spi_valid is high.
REQ-011 Port o_spi_data  out  8  byte to send.
REQ-012 Port i_spi_ready  in  1  sender accepts the byte this cycle.
REQ-013 Port o_busy  out  1  high in every state except IDLE and DONE.
REQ-014 Port o_init_done  out  1  high while in DONE.

Function
REQ-015 States SHALL be IDLE, HW_RST, RST_WAIT, FETCH, SEND, DELAY, DONE.
REQ-016 IDLE/DONE + i_start -> HW_RST; HW_RST lasts 1 cycle with o_reset_ena=1, o_reset_val=LOW -> RST_WAIT.
REQ-017 RST_WAIT: hold until i_reset_sent=1, then clear the table pointer to 0 -> FETCH.
REQ-018 The table SHALL be a fixed internal ROM of 10-bit entries {type[1:0], byte[7:0]}: type 00 command, 01 data, 10 long delay, 11 end.
REQ-019 Table order: 0x11(cmd), delay, 0x3A(cmd), 0x55(data), 0x36(cmd), 0x48(data), 0x29(cmd), delay, end.
REQ-020 FETCH (1 cycle): type 00/01 -> SEND; type 10 -> DELAY, load counter with WAIT_120MS-1; type 11 -> DONE.
REQ-021 SEND: o_spi_valid=1, o_spi_dc=type[0], o_spi_data=byte, held stable until i_spi_ready=1.
REQ-022 In a SEND cycle with i_spi_ready=1, the pointer SHALL increment and the next state SHALL be FETCH, so o_spi_valid drops for at least one cycle between bytes.
REQ-023 i_spi_ready asserted outside SEND SHALL be ignored.
REQ-024 DELAY SHALL last exactly WAIT_120MS cycles: counter decrements each cycle; at zero, pointer increments -> FETCH.
REQ-025 The pointer SHALL never wrap; the end entry terminates the sequence.
REQ-026 i_start in any busy state SHALL be ignored; i_start in DONE SHALL restart the full sequence from HW_RST.
REQ-027 o_reset_ena, o_spi_valid and o_spi_dc SHALL be 0, and o_spi_data SHALL be 0x00, in every state where they are not driven as above.

Reset
REQ-028 rst low SHALL immediately force IDLE, pointer 0, counter 0, and outputs o_reset_ena=0, o_reset_val=HIGH, o_spi_valid=0, o_spi_dc=0, o_spi_data=0x00, o_busy=0, o_init_done=0.
REQ-029 Reset asserted mid-SEND or mid-DELAY SHALL abandon the sequence; after release the block waits in IDLE for i_start.

Configuration
REQ-030 Macro INIT_SEQ_SWRESET_EN: when defined, the table SHALL be prefixed with 0x01(cmd) followed by a delay entry, ahead of the REQ-019 order.
REQ-031 When INIT_SEQ_SWRESET_EN is undefined, the table SHALL be exactly the REQ-019 order.

Verification (WAIT_120MS=8, macro undefined unless noted)
REQ-032 Pulse i_start, pulse i_reset_sent 5 cycles later, i_spi_ready tied 1 -> bytes 0x11, 0x3A, 0x55, 0x36, 0x48, 0x29 with dc 0,0,1,0,1,0; o_init_done=1.
REQ-033 During the gap after 0x11, o_spi_valid SHALL stay 0 for exactly 8 DELAY cycles plus the FETCH cycles.
REQ-034 With i_spi_ready held 0 for 20 cycles during byte 0x3A -> o_spi_valid, o_spi_data=0x3A and o_spi_dc=0 stay stable for all 20 cycles, with no pointer advance.
REQ-035 Assert rst during DELAY -> all outputs take their reset values in the same cycle; the block stays in IDLE after release until i_start.
REQ-036 Pulse i_start during SEND -> no effect; pulse i_start in DONE -> o_reset_ena pulses once and the sequence repeats.
REQ-037 Macro defined -> the first byte is 0x01 (dc=0), followed by an 8-cycle delay, then 0x11.
